// File: rtl/mdl_timer_serial_pkg.sv
// Shared definitions for the bit-serial frame timer: mode encodings, slot
// counter sizing and the phase decode points within a frame.
package mdl_timer_serial_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Where a slot sits within the frame
    typedef enum logic [1:0] {
        PhShift,
        PhEval,
        PhIdle
    } phase_e;

    // Bits needed to hold slot numbers 0..frame-1
    function automatic int unsigned slot_width(input int unsigned frame);
        return (frame <= 2) ? 1 : $clog2(frame);
    endfunction

    // Last slot of the shift phase: the new count is complete after it
    function automatic int unsigned shift_end_slot(input int unsigned width);
        return width - 1;
    endfunction

    // First slot after the shift phase: match strobe and deferred latch
    function automatic int unsigned eval_slot(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/mdl_timer_serial_if.sv
// Control/status bundle of the serial timer. The sequencer side drives the
// requests and observes the flags; the timer implements the slave side.
interface mdl_timer_serial_if
    import mdl_timer_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FRAME = 20
) ();

    logic                           i_CLK2M_PCEN_n;
    logic                           i_FRAME_SYNC_n;
    logic                           i_CNT;
    logic                           i_CLR;
    logic                           i_MODE;
    logic [WIDTH-1:0]               i_TC;
    logic                           i_OUTLATCH_LD_n;
    logic                           o_TIMEOVER_n;
    logic                           o_MATCH_PULSE;
    logic                           o_SYNCERR;
    logic [WIDTH-1:0]               o_CNTREG;
    logic [slot_width(FRAME)-1:0]   o_SLOT;

    modport master (
        output i_CLK2M_PCEN_n, i_FRAME_SYNC_n, i_CNT, i_CLR, i_MODE, i_TC, i_OUTLATCH_LD_n,
        input  o_TIMEOVER_n, o_MATCH_PULSE, o_SYNCERR, o_CNTREG, o_SLOT
    );

    modport slave (
        input  i_CLK2M_PCEN_n, i_FRAME_SYNC_n, i_CNT, i_CLR, i_MODE, i_TC, i_OUTLATCH_LD_n,
        output o_TIMEOVER_n, o_MATCH_PULSE, o_SYNCERR, o_CNTREG, o_SLOT
    );

endinterface

// File: rtl/mdl_serial_addcmp.sv
// Serial full adder with carry flop plus a running equality accumulator.
// One counter bit is processed per enabled tick, LSB first.
module mdl_serial_addcmp (
    input  logic i_MCLK,
    input  logic i_RST_n,
    input  logic i_en,      // process one bit this tick
    input  logic i_first,   // bit 0: start with zero carry and a fresh equality
    input  logic i_clr,     // frame abort: drop carry and equality
    input  logic i_a,       // current counter bit
    input  logic i_cin,     // increment, only meaningful on bit 0
    input  logic i_zero,    // force the written bit to 0
    input  logic i_tc,      // terminal count bit at the same position
    output logic o_bit,     // bit written back to the counter
    output logic o_eq       // equality including this bit
);

    logic carry_q;
    logic eq_q;
    logic c_in;
    logic sum;
    logic c_next;

    // Full adder and equality for the bit in flight
    always_comb begin
        c_in   = i_first ? 1'b0 : carry_q;
        sum    = i_a ^ c_in ^ i_cin;
        c_next = (i_a & c_in) | (i_a & i_cin) | (c_in & i_cin);
        o_bit  = sum & ~i_zero;
        // Compare against the value actually written, i.e. the new count
        o_eq   = (i_first | eq_q) & ~(o_bit ^ i_tc);
    end

    // Carry and equality state between bits
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else if (i_clr) begin
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else if (i_en) begin
            carry_q <= c_next;
            eq_q    <= o_eq;
        end
    end

endmodule

// File: rtl/mdl_timer_serial.sv
// Bit-serial frame timer. The count lives in a shift register that rotates
// through one serial adder per frame; a terminal-count compare drives a
// sticky time-over (one-shot) or an automatic reload on the next frame.
module mdl_timer_serial
    import mdl_timer_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FRAME = 20
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    mdl_timer_serial_if.slave bus
);

    localparam int unsigned   SW             = slot_width(FRAME);
    localparam logic [SW-1:0] SLOT_SHIFT_END = SW'(shift_end_slot(WIDTH));
    localparam logic [SW-1:0] SLOT_EVAL      = SW'(eval_slot(WIDTH));
    localparam logic [SW-1:0] SLOT_LAST      = SW'(FRAME - 1);

    logic [SW-1:0]    slot_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] tc_sh_q;
    logic [WIDTH-1:0] cntreg_q;
    logic             cnt_sh_q;
    logic             clr_sh_q;
    logic             mode_sh_q;
    logic             timeover_q;
    logic             pulse_q;
    logic             syncerr_q;
    logic             pend_q;
    logic             reload_q;

    phase_e phase;
    logic   tick;
    logic   sync;
    logic   first;
    logic   in_shift;
    logic   shift_end;
    logic   at_eval;
    logic   abort;
    logic   shift_en;
    logic   cnt_eff;
    logic   clr_eff;
    logic   mode_eff;
    logic   tc_bit;
    logic   held;
    logic   cin;
    logic   zero_force;
    logic   wbit;
    logic   eq_next;
    logic   match;
    logic   latch_req;

    // Slot phase decode and per-tick control terms
    always_comb begin
        if (slot_q <= SLOT_SHIFT_END) begin
            phase = PhShift;
        end else if (slot_q == SLOT_EVAL) begin
            phase = PhEval;
        end else begin
            phase = PhIdle;
        end
        tick      = ~bus.i_CLK2M_PCEN_n;
        sync      = ~bus.i_FRAME_SYNC_n;
        latch_req = ~bus.i_OUTLATCH_LD_n;
        first     = (slot_q == '0);
        in_shift  = (phase == PhShift);
        at_eval   = (phase == PhEval);
        shift_end = (slot_q == SLOT_SHIFT_END);
        // Sync inside the shift phase (past bit 0) tears the frame down
        abort     = tick & sync & ~first & in_shift;
        // Sync on slot 0 only holds alignment; bit 0 runs on the following tick
        shift_en  = tick & in_shift & ~abort & ~(sync & first);
        // Slot 0 consumes the live requests; later bits use the shadows
        cnt_eff   = first ? bus.i_CNT  : cnt_sh_q;
        clr_eff   = first ? bus.i_CLR  : clr_sh_q;
        mode_eff  = first ? bus.i_MODE : mode_sh_q;
        tc_bit    = first ? bus.i_TC[0] : tc_sh_q[0];
        // One-shot stops incrementing once it has timed over, holding at TC
        held       = (mode_eff == MODE_ONESHOT) & timeover_q;
        cin        = first & cnt_eff & ~held;
        zero_force = clr_eff | ((mode_eff == MODE_RELOAD) & reload_q);
        match      = shift_en & shift_end & eq_next & ~clr_eff;
    end

    mdl_serial_addcmp u_addcmp (
        .i_MCLK  (i_MCLK),
        .i_RST_n (i_RST_n),
        .i_en    (shift_en),
        .i_first (first),
        .i_clr   (abort),
        .i_a     (cnt_q[0]),
        .i_cin   (cin),
        .i_zero  (zero_force),
        .i_tc    (tc_bit),
        .o_bit   (wbit),
        .o_eq    (eq_next)
    );

    // Slot sequencer, counter rotation, frame evaluation and output latch
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            slot_q     <= '0;
            cnt_q      <= '0;
            tc_sh_q    <= '0;
            cntreg_q   <= '0;
            cnt_sh_q   <= 1'b0;
            clr_sh_q   <= 1'b0;
            mode_sh_q  <= MODE_ONESHOT;
            timeover_q <= 1'b0;
            pulse_q    <= 1'b0;
            syncerr_q  <= 1'b0;
            pend_q     <= 1'b0;
            reload_q   <= 1'b0;
        end else if (tick) begin
            if (sync || slot_q == SLOT_LAST) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_q + SW'(1);
            end

            pulse_q <= 1'b0;

            if (abort) begin
                cnt_q     <= '0;
                syncerr_q <= 1'b1;
            end else if (shift_en) begin
                cnt_q <= {wbit, cnt_q[WIDTH-1:1]};
                if (first) begin
                    tc_sh_q   <= bus.i_TC >> 1;
                    cnt_sh_q  <= bus.i_CNT;
                    clr_sh_q  <= bus.i_CLR;
                    mode_sh_q <= bus.i_MODE;
                end else begin
                    tc_sh_q <= tc_sh_q >> 1;
                end
                if (shift_end) begin
                    if (clr_eff) begin
                        timeover_q <= 1'b0;
                        syncerr_q  <= 1'b0;
                        reload_q   <= 1'b0;
                    end else begin
                        reload_q <= match & (mode_eff == MODE_RELOAD);
                        // A held one-shot keeps matching but strobes only once
                        pulse_q  <= match & ~held;
                        if (match && mode_eff == MODE_ONESHOT) begin
                            timeover_q <= 1'b1;
                        end
                    end
                end
            end

            // Loads during the shift phase wait for the finished count
            if (!in_shift && (latch_req || (pend_q && at_eval))) begin
                cntreg_q <= cnt_q;
                pend_q   <= 1'b0;
            end else if (in_shift && latch_req) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign bus.o_TIMEOVER_n  = ~timeover_q;
    assign bus.o_MATCH_PULSE = pulse_q;
    assign bus.o_SYNCERR     = syncerr_q;
    assign bus.o_CNTREG      = cntreg_q;
    assign bus.o_SLOT        = slot_q;

endmodule

// File: tb/tb_mdl_timer_serial.sv
// Self-checking bench for mdl_timer_serial with a frame-level reference model
// and a scoreboard of per-frame expectations.
`timescale 1ns/1ps
module tb_mdl_timer_serial;
    import mdl_timer_serial_pkg::*;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned FRAME = 20;
    localparam int unsigned SW    = slot_width(FRAME);
    localparam int          W     = int'(WIDTH);

    logic i_MCLK = 1'b0;
    logic i_RST_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mdl_timer_serial_if #(.WIDTH(WIDTH), .FRAME(FRAME)) bus ();

    mdl_timer_serial #(.WIDTH(WIDTH), .FRAME(FRAME)) dut (
        .i_MCLK  (i_MCLK),
        .i_RST_n (i_RST_n),
        .bus     (bus)
    );

    always #5 i_MCLK = ~i_MCLK;

    typedef struct {
        logic             has_latch;
        logic [WIDTH-1:0] cntreg;
        logic             pulse;
        logic             timeover_n;
        logic             syncerr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [WIDTH-1:0] m_v;
    logic [WIDTH-1:0] m_cntreg;
    logic             m_to;
    logic             m_serr;
    logic             m_reload;

    function automatic logic [FRAME-1:0] one_at(input int s);
        logic [FRAME-1:0] one;
        one = {{(FRAME-1){1'b0}}, 1'b1};
        return one << s;
    endfunction

    task automatic model_reset();
        m_v = '0; m_cntreg = '0; m_to = 1'b0; m_serr = 1'b0; m_reload = 1'b0;
        exp_q.delete();
    endtask

    // One full frame from slot 0; latch requests at the slots set in latch_mask,
    // optional clock-enable gap before the tick at gap_slot.
    task automatic run_frame(input logic cnt, input logic clr, input logic mode,
                             input logic [WIDTH-1:0] tc, input logic [FRAME-1:0] latch_mask,
                             input int gap_slot);
        exp_t             e;
        exp_t             cur;
        int               land;
        int               pulses;
        logic [WIDTH-1:0] prev_reg;
        logic             add;
        logic             match;
        logic             held;

        held = (mode == MODE_ONESHOT) && m_to;
        add  = cnt && !held;
        if (clr || (mode == MODE_RELOAD && m_reload)) m_v = '0;
        else m_v = m_v + {{(WIDTH-1){1'b0}}, add};
        match   = !clr && (m_v == tc);
        e.pulse = match && !held;
        if (clr) begin
            m_to = 1'b0; m_serr = 1'b0; m_reload = 1'b0;
        end else begin
            m_reload = (mode == MODE_RELOAD) && match;
            if (match && mode == MODE_ONESHOT) m_to = 1'b1;
        end
        e.timeover_n = !m_to;
        e.syncerr    = m_serr;
        e.has_latch  = |latch_mask;
        e.cntreg     = m_v;
        prev_reg     = m_cntreg;
        land = -1;
        for (int s = int'(FRAME) - 1; s >= 0; s--) if (latch_mask[s]) land = s;
        if (land >= 0 && land < W) land = W;
        if (land >= 0) m_cntreg = m_v;
        exp_q.push_back(e);
        cur = e;

        pulses = 0;
        for (int s = 0; s < int'(FRAME); s++) begin
            if (s == 0) begin
                bus.i_CNT = cnt; bus.i_CLR = clr; bus.i_MODE = mode; bus.i_TC = tc;
            end else begin
                // Requests away from slot 0 must be ignored
                bus.i_CNT  = 1'($urandom_range(0, 1));
                bus.i_CLR  = 1'($urandom_range(0, 1));
                bus.i_MODE = 1'($urandom_range(0, 1));
                bus.i_TC   = WIDTH'($urandom);
            end
            bus.i_OUTLATCH_LD_n = ~latch_mask[s];
            if (s == gap_slot) begin
                bus.i_CLK2M_PCEN_n = 1'b1;
                repeat (3) @(posedge i_MCLK);
                #1;
                checks++;
                if (bus.o_SLOT !== SW'(s)) begin
                    failures++;
                    $display("FAIL gap_slot_hold got=%0d exp=%0d", bus.o_SLOT, s);
                end
                bus.i_CLK2M_PCEN_n = 1'b0;
            end
            @(posedge i_MCLK);
            #1;
            if (bus.o_MATCH_PULSE === 1'b1) pulses++;
            if (s == W - 1) begin
                cur = exp_q.pop_front();
                checks++;
                if (bus.o_MATCH_PULSE !== cur.pulse) begin
                    failures++;
                    $display("FAIL match_pulse got=%0b exp=%0b val=%0d",
                             bus.o_MATCH_PULSE, cur.pulse, cur.cntreg);
                end
                checks++;
                if (bus.o_TIMEOVER_n !== cur.timeover_n) begin
                    failures++;
                    $display("FAIL timeover_n got=%0b exp=%0b val=%0d",
                             bus.o_TIMEOVER_n, cur.timeover_n, cur.cntreg);
                end
                checks++;
                if (bus.o_SYNCERR !== cur.syncerr) begin
                    failures++;
                    $display("FAIL syncerr got=%0b exp=%0b", bus.o_SYNCERR, cur.syncerr);
                end
            end
            if (land > 0 && s == land - 1) begin
                checks++;
                if (bus.o_CNTREG !== prev_reg) begin
                    failures++;
                    $display("FAIL cntreg_early got=%0d exp=%0d", bus.o_CNTREG, prev_reg);
                end
            end
            if (cur.has_latch && s == land) begin
                checks++;
                if (bus.o_CNTREG !== cur.cntreg) begin
                    failures++;
                    $display("FAIL cntreg got=%0d exp=%0d slot=%0d", bus.o_CNTREG, cur.cntreg, s);
                end
            end
        end
        checks++;
        if (pulses != (e.pulse ? 1 : 0)) begin
            failures++;
            $display("FAIL pulse_count got=%0d exp=%0d", pulses, e.pulse ? 1 : 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.o_SLOT !== '0 || bus.o_CNTREG !== '0 || bus.o_TIMEOVER_n !== 1'b1 ||
            bus.o_MATCH_PULSE !== 1'b0 || bus.o_SYNCERR !== 1'b0) begin
            failures++;
            $display("FAIL %s got slot=%0d reg=%0d ton=%0b mp=%0b se=%0b exp 0 0 1 0 0", tag,
                     bus.o_SLOT, bus.o_CNTREG, bus.o_TIMEOVER_n, bus.o_MATCH_PULSE,
                     bus.o_SYNCERR);
        end
    endtask

    task automatic test_reset();
        bus.i_CLK2M_PCEN_n = 1'b0; bus.i_FRAME_SYNC_n = 1'b1; bus.i_OUTLATCH_LD_n = 1'b1;
        bus.i_CNT = 1'b0; bus.i_CLR = 1'b0; bus.i_MODE = MODE_ONESHOT; bus.i_TC = '0;
        i_RST_n = 1'b0;
        repeat (3) @(posedge i_MCLK);
        #1;
        check_reset_outputs("reset_values");
        i_RST_n = 1'b1;
        model_reset();
    endtask

    task automatic test_oneshot();
        for (int f = 0; f < 2557; f++) begin
            run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd2555, one_at(13), -1);
        end
    endtask

    task automatic test_async_reset();
        bus.i_OUTLATCH_LD_n = 1'b1; bus.i_CNT = 1'b1; bus.i_CLR = 1'b0;
        bus.i_MODE = MODE_ONESHOT; bus.i_TC = 12'd2555;
        repeat (9) @(posedge i_MCLK);
        #1;
        checks++;
        if (bus.o_SLOT !== SW'(9) || bus.o_TIMEOVER_n !== !m_to) begin
            failures++;
            $display("FAIL pre_reset got slot=%0d ton=%0b exp slot=9 ton=%0b",
                     bus.o_SLOT, bus.o_TIMEOVER_n, !m_to);
        end
        #2;
        i_RST_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge i_MCLK);
        #1;
        i_RST_n = 1'b1;
        model_reset();
        checks++;
        if (bus.o_SLOT !== '0) begin
            failures++;
            $display("FAIL slot_after_reset got=%0d exp=0", bus.o_SLOT);
        end
    endtask

    task automatic test_clr_at_tc();
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd3, one_at(13), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd3, one_at(13), -1);
        run_frame(1'b1, 1'b1, MODE_ONESHOT, 12'd3, one_at(13), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd3, one_at(13), -1);
    endtask

    task automatic test_reload();
        run_frame(1'b0, 1'b1, MODE_RELOAD, 12'd3, one_at(13), -1);
        for (int f = 0; f < 8; f++) begin
            run_frame(1'b1, 1'b0, MODE_RELOAD, 12'd3, one_at(14), -1);
        end
    endtask

    task automatic test_latch();
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, one_at(5), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, one_at(15), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, one_at(3) | one_at(5) | one_at(9), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, one_at(5), 4);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, '0, -1);
    endtask

    task automatic test_sync_abort();
        run_frame(1'b0, 1'b1, MODE_ONESHOT, 12'd4000, '0, -1);
        for (int f = 0; f < 100; f++) begin
            run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd4000, '0, -1);
        end
        bus.i_CNT = 1'b1; bus.i_CLR = 1'b0; bus.i_MODE = MODE_ONESHOT; bus.i_TC = 12'd4000;
        bus.i_OUTLATCH_LD_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            if (s == 7) bus.i_FRAME_SYNC_n = 1'b0;
            @(posedge i_MCLK);
            #1;
        end
        bus.i_FRAME_SYNC_n = 1'b1;
        m_v = '0;
        m_serr = 1'b1;
        checks++;
        if (bus.o_SLOT !== '0 || bus.o_SYNCERR !== 1'b1 || bus.o_TIMEOVER_n !== !m_to) begin
            failures++;
            $display("FAIL abort got slot=%0d se=%0b ton=%0b exp slot=0 se=1 ton=%0b",
                     bus.o_SLOT, bus.o_SYNCERR, bus.o_TIMEOVER_n, !m_to);
        end
        run_frame(1'b0, 1'b0, MODE_ONESHOT, 12'd4000, one_at(13), -1);
        run_frame(1'b0, 1'b1, MODE_ONESHOT, 12'd4000, one_at(13), -1);
    endtask

    task automatic test_tc_zero();
        run_frame(1'b0, 1'b1, MODE_RELOAD, 12'd0, one_at(13), -1);
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 1'b0, MODE_RELOAD, 12'd0, one_at(13), -1);
        end
        run_frame(1'b0, 1'b1, MODE_ONESHOT, 12'd0, one_at(13), -1);
        run_frame(1'b0, 1'b0, MODE_ONESHOT, 12'd0, one_at(13), -1);
        run_frame(1'b1, 1'b0, MODE_ONESHOT, 12'd0, one_at(13), -1);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_async_reset();
        test_clr_at_tc();
        test_reload();
        test_latch();
        test_sync_abort();
        test_tc_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
